mips_cpu_alu_muldiv_iter: RTL

- Parametrised, multi-cycle successor to the single-cycle HI/LO multiply/divide unit beside the ALU.
- Performs signed and unsigned multiply and divide into HI/LO, one bit per cycle, using a start/busy/done handshake.
- Also supports MTHI/MTLO writes and an abort for exception flushes.
- The CPU FSM stalls MFHI/MFLO while busy is high.

---
 rtl/mips_cpu_alu_muldiv_pkg.sv | 23 ++
 rtl/mips_cpu_alu_div_step.sv | 23 ++
 rtl/mips_cpu_alu_muldiv_iter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_alu_muldiv_pkg.sv
// rtl/mips_cpu_alu_muldiv_pkg.sv - shared types for the iterative HI/LO multiply/divide unit
package mips_cpu_alu_muldiv_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 3'b000,
      OP_MULT  = 3'b001,
      OP_MULTU = 3'b010,
      OP_DIV   = 3'b011,
      OP_DIVU  = 3'b100,
      OP_MTHI  = 3'b101,
      OP_MTLO  = 3'b110,
      OP_RSVD  = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2
   } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_alu_div_step.sv
// rtl/mips_cpu_alu_div_step.sv - one restoring-divide iteration (combinational)
module mips_cpu_alu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem_in < divisor, so shifted < 2*divisor and bit WIDTH of diff is a clean borrow flag
   always_comb begin
      shifted = {rem_in, dividend_bit};
      diff    = shifted - {1'b0, divisor};
      q_bit   = ~diff[WIDTH];
      rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/mips_cpu_alu_muldiv_iter.sv
// rtl/mips_cpu_alu_muldiv_iter.sv - iterative signed/unsigned HI/LO multiply/divide unit
// Define MIPS_CPU_MULT_FAST_EN for a single-cycle combinational MULT/MULTU path.
module mips_cpu_alu_muldiv_iter
   import mips_cpu_alu_muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   muldiv_state_t      state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               is_div_q, is_div_d;
   logic               dz_q, dz_d;
   logic               done_q, done_d;
   logic               div_zero_q, div_zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   muldiv_op_t         op_e;
   logic               sgn_op;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, div_next;
   logic [WIDTH-1:0]   step_rem;
   logic               step_q;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   assign op_e   = muldiv_op_t'(op);
   assign sgn_op = (op_e == OP_MULT) || (op_e == OP_DIV);
   assign mag_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
   assign mag_b  = (sgn_op && b[WIDTH-1]) ? -b : b;

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
   mips_cpu_alu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in       (acc_q[2*WIDTH-1:WIDTH]),
      .dividend_bit (acc_q[WIDTH-1]),
      .divisor      (opb_q),
      .rem_out      (step_rem),
      .q_bit        (step_q)
   );
   assign div_next = {step_rem, acc_q[WIDTH-2:0], step_q};

   always_comb begin
      fix_hi = acc_q[2*WIDTH-1:WIDTH];
      fix_lo = acc_q[WIDTH-1:0];
      if (!dz_q) begin
         if (is_div_q) begin
            if (neg_q)  fix_lo = -acc_q[WIDTH-1:0];
            if (rneg_q) fix_hi = -acc_q[2*WIDTH-1:WIDTH];
         end else if (neg_q) begin
            {fix_hi, fix_lo} = -acc_q;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      neg_d      = neg_q;
      rneg_d     = rneg_q;
      is_div_d   = is_div_q;
      dz_d       = dz_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               case (op_e)
                  OP_MULT, OP_MULTU: begin
                     neg_d      = sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                     rneg_d     = 1'b0;
                     is_div_d   = 1'b0;
                     dz_d       = 1'b0;
                     div_zero_d = 1'b0;
                     cnt_d      = '0;
                     opb_d      = mag_a;
`ifdef MIPS_CPU_MULT_FAST_EN
                     acc_d      = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                     state_d    = FIX;
`else
                     acc_d      = {{WIDTH{1'b0}}, mag_b};
                     state_d    = BUSY;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     neg_d      = sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                     rneg_d     = sgn_op & a[WIDTH-1];
                     is_div_d   = 1'b1;
                     cnt_d      = '0;
                     opb_d      = mag_b;
                     dz_d       = (b == '0);
                     div_zero_d = (b == '0);
                     if (b == '0) begin
                        // FIX passes acc through untouched when dz_q is set
                        acc_d   = {a, {WIDTH{1'b1}}};
                        state_d = FIX;
                     end else begin
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                        state_d = BUSY;
                     end
                  end
                  OP_MTHI: begin
                     hi_d       = a;
                     div_zero_d = 1'b0;
                  end
                  OP_MTLO: begin
                     lo_d       = a;
                     div_zero_d = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         BUSY: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               acc_d = is_div_q ? div_next : mul_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!abort) begin
               hi_d   = fix_hi;
               lo_d   = fix_lo;
               done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         is_div_q   <= 1'b0;
         dz_q       <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         neg_q      <= neg_d;
         rneg_q     <= rneg_d;
         is_div_q   <= is_div_d;
         dz_q       <= dz_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule
